// File: rtl/ysyx_22041412_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// UNROLL result bits per CALC cycle, valid/ready on both request and result.
module ysyx_22041412_mdu #(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic            word,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN / UNROLL + 1);
  localparam logic [XLEN-1:0] MINX   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] LO32   = XLEN'({32{1'b1}});
  localparam logic [CW-1:0]   N_FULL = CW'(XLEN / UNROLL);
  localparam logic [CW-1:0]   N_WORD = CW'(32 / UNROLL);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, x_q, x_d, res_q, res_d;
  logic [2*XLEN-1:0] y_q, y_d, acc_q, acc_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;

  logic [XLEN-1:0]   a_w, b_w, ma, mb, min_w, quo, rem, sel;
  logic              sa, sb, is_div, div_zero, div_ovf;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     part;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Operand preparation and sign fix-up, shared by PREP and FIX.
  always_comb begin
    is_div   = op_q[2];
    a_w      = word_q ? sext32(a_q[31:0]) : a_q;
    b_w      = word_q ? sext32(b_q[31:0]) : b_q;
    sa       = (is_div ? ~op_q[0] : (op_q[1:0] != 2'b11)) & a_w[XLEN-1];
    sb       = (is_div ? ~op_q[0] : ~op_q[1]) & b_w[XLEN-1];
    ma       = word_q ? (neg_if(a_w, sa) & LO32) : neg_if(a_w, sa);
    mb       = word_q ? (neg_if(b_w, sb) & LO32) : neg_if(b_w, sb);
    min_w    = word_q ? sext32(32'h8000_0000) : MINX;
    div_zero = (b_w == '0);
    div_ovf  = ~op_q[0] & (a_w == min_w) & (b_w == '1);
    prod     = qneg_q ? -acc_q : acc_q;
    quo      = neg_if(x_q, qneg_q);
    rem      = neg_if(acc_q[XLEN-1:0], rneg_q);
    case (op_q)
      3'b000:                 sel = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sel = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sel = quo;
      default:                sel = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    word_d  = word_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    res_d   = res_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    part    = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          // High-half multiplies have no W form; they execute as MULW.
          op_d    = (word && !func3[2]) ? 3'b000 : func3;
          word_d  = word;
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        qneg_d = sa ^ sb;
        rneg_d = sa;
        acc_d  = '0;
        if (is_div && (div_zero || div_ovf)) begin
          if (div_zero) res_d = op_q[1] ? a_w : '1;
          else          res_d = op_q[1] ? '0 : a_w;
          state_d = S_DONE;
        end else begin
          cnt_d   = word_q ? N_WORD : N_FULL;
          state_d = S_CALC;
          if (is_div) begin
            // Dividend is left-aligned so its MSB always leaves from bit XLEN-1.
            x_d = word_q ? (ma << (XLEN - 32)) : ma;
            y_d = {{XLEN{1'b0}}, mb};
          end else begin
            x_d = mb;
            y_d = {{XLEN{1'b0}}, ma};
          end
        end
      end
      S_CALC: begin
        for (int u = 0; u < UNROLL; u++) begin
          if (is_div) begin
            part = {acc_d[XLEN-1:0], x_d[XLEN-1]};
            x_d  = x_d << 1;
            if (part >= {1'b0, y_d[XLEN-1:0]}) begin
              part   = part - {1'b0, y_d[XLEN-1:0]};
              x_d[0] = 1'b1;
            end
            acc_d = {{XLEN{1'b0}}, part[XLEN-1:0]};
          end else begin
            if (x_d[0]) acc_d = acc_d + y_d;
            y_d = y_d << 1;
            x_d = x_d >> 1;
          end
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = word_q ? sext32(sel[31:0]) : sel;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      word_q  <= word_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = res_q;

endmodule
